// File: rtl/updown_counter_driver.sv
// Command sequencer for a 4-bit up/down counter: FIFO-buffered {op,value,rep} commands drive load/data/updown.
// Optional wrap flag output is built when CNT_DRV_WRAP_FLAG_EN is defined.
module updown_counter_driver #(
   parameter int WIDTH      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int REP_W      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_op,
   input  logic [WIDTH-1:0]              cmd_value,
   input  logic [REP_W-1:0]              cmd_rep,
   output logic                          load,
   output logic [WIDTH-1:0]              data,
   output logic                          updown,
   output logic [WIDTH-1:0]              exp_count,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef CNT_DRV_WRAP_FLAG_EN
   ,
   output logic                          wrap
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = 2 + WIDTH + REP_W;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [0:0]       r_state;
   logic [REP_W-1:0] r_rem;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_value;
   logic             r_load;
   logic             r_updown;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_exp;

   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_repeat;
   logic [ENT_W-1:0] w_head;
   logic [1:0]       w_head_op;
   logic [WIDTH-1:0] w_head_value;
   logic [REP_W-1:0] w_head_rep;
   logic [1:0]       w_step_op;
   logic [WIDTH-1:0] w_step_value;
   logic [0:0]       w_next_state;
   logic [REP_W-1:0] w_next_rem;
   logic [WIDTH-1:0] w_exp_next;

   assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
   assign cmd_ready    = !w_full && !rst;
   assign w_push       = cmd_valid && cmd_ready;
   assign w_repeat     = (r_state == S_RUN) && (r_rem != {REP_W{1'b0}});
   assign w_pop        = !w_repeat && (r_level != {LVL_W{1'b0}});
   assign w_head       = r_mem[r_rd_ptr];
   assign w_head_op    = w_head[ENT_W-1 -: 2];
   assign w_head_value = w_head[REP_W +: WIDTH];
   assign w_head_rep   = w_head[REP_W-1:0];

   assign load       = r_load;
   assign data       = r_data;
   assign updown     = r_updown;
   assign exp_count  = r_exp;
   assign fifo_level = r_level;
   assign busy       = (r_state == S_RUN) || (r_level != {LVL_W{1'b0}});

   // FIFO storage; the entry is only read after it has been written, so no reset is needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cmd_op, cmd_value, cmd_rep};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_level  <= {LVL_W{1'b0}};
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Choose the step to drive next: repeat, start a popped command, or hold
   always_comb begin
      w_step_op    = OP_HOLD;
      w_step_value = r_value;
      w_next_state = S_IDLE;
      w_next_rem   = {REP_W{1'b0}};
      if (w_repeat) begin
         w_step_op    = r_op;
         w_next_state = S_RUN;
         w_next_rem   = r_rem - REP_W'(1);
      end else if (w_pop) begin
         w_step_op    = w_head_op;
         w_step_value = w_head_value;
         w_next_state = S_RUN;
         w_next_rem   = w_head_rep;
      end else begin
         w_step_op    = OP_HOLD;
         w_next_state = S_IDLE;
      end
   end

   // Count the counter will hold after this edge, derived from the pins it sees now
   always_comb begin
      if (r_load) begin
         w_exp_next = r_data;
      end else if (r_updown) begin
         w_exp_next = r_exp + WIDTH'(1);
      end else begin
         w_exp_next = r_exp - WIDTH'(1);
      end
   end

   // Sequencer state and the command currently being repeated
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rem   <= {REP_W{1'b0}};
         r_op    <= OP_HOLD;
         r_value <= {WIDTH{1'b0}};
      end else begin
         r_state <= w_next_state;
         r_rem   <= w_next_rem;
         if (w_pop) begin
            r_op    <= w_head_op;
            r_value <= w_head_value;
         end else begin
            r_op    <= r_op;
            r_value <= r_value;
         end
      end
   end

   // Counter pins and shadow count; hold is done by reloading the value the counter will have
   always_ff @(posedge clk) begin
      if (rst) begin
         r_load   <= 1'b1;
         r_data   <= {WIDTH{1'b0}};
         r_updown <= 1'b0;
         r_exp    <= {WIDTH{1'b0}};
      end else begin
         r_exp <= w_exp_next;
         case (w_step_op)
            OP_LOAD: begin
               r_load <= 1'b1;
               r_data <= w_step_value;
            end
            OP_UP: begin
               r_load   <= 1'b0;
               r_updown <= 1'b1;
            end
            OP_DOWN: begin
               r_load   <= 1'b0;
               r_updown <= 1'b0;
            end
            default: begin
               r_load <= 1'b1;
               r_data <= w_exp_next;
            end
         endcase
      end
   end

`ifdef CNT_DRV_WRAP_FLAG_EN
   logic r_wrap;
   assign wrap = r_wrap;

   // Flag the count update that crosses the modular boundary; loads never count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= !r_load && (r_updown ? (r_exp == {WIDTH{1'b1}}) : (r_exp == {WIDTH{1'b0}}));
      end
   end
`endif

endmodule

// File: tb/tb_updown_counter_driver.sv
// Self-checking bench: command-level queue model plus a behavioural counter fed from the DUT pins.
module tb_updown_counter_driver;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int REP_W = 4;
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b00;
   logic [WIDTH-1:0] cmd_value = 4'h0;
   logic [REP_W-1:0] cmd_rep = 4'h0;
   logic             load;
   logic [WIDTH-1:0] data;
   logic             updown;
   logic [WIDTH-1:0] exp_count;
   logic             busy;
   logic [2:0]       fifo_level;
`ifdef CNT_DRV_WRAP_FLAG_EN
   logic             wrap;
`endif

   always #5 clk = ~clk;

   updown_counter_driver #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .REP_W(REP_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_value(cmd_value), .cmd_rep(cmd_rep),
      .load(load), .data(data), .updown(updown), .exp_count(exp_count),
      .busy(busy), .fifo_level(fifo_level)
`ifdef CNT_DRV_WRAP_FLAG_EN
      , .wrap(wrap)
`endif
   );

   typedef struct packed {
      logic [1:0]       op;
      logic [WIDTH-1:0] value;
      logic             first;
   } step_t;

   step_t            m_q[$];
   int               m_lvl = 0;
   bit               m_run = 1'b0;
   logic             m_load = 1'b1;
   logic             m_updown = 1'b0;
   logic [WIDTH-1:0] m_data = 4'h0;
   logic [WIDTH-1:0] m_exp = 4'h0;
   logic [WIDTH-1:0] c_cnt = 4'h0;
`ifdef CNT_DRV_WRAP_FLAG_EN
   bit               m_wrap = 1'b0;
`endif
   bit               last_accept = 1'b0;
   int               n_checks = 0;
   int               n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // One clock: check ready, advance the model across the edge, then check every output
   task automatic tick();
      bit               p_rst;
      bit               p_ready;
      bit               p_push;
      logic [1:0]       p_op;
      logic [WIDTH-1:0] p_val;
      logic [REP_W-1:0] p_rep;
      logic             p_load;
      logic             p_updown;
      logic [WIDTH-1:0] p_data;
      logic [WIDTH-1:0] e_new;
      step_t            s;
      #1;
      p_rst   = rst;
      p_ready = !rst && (m_lvl < DEPTH);
      check_val("cmd_ready", {31'b0, cmd_ready}, {31'b0, p_ready});
      p_push   = cmd_valid && p_ready;
      p_op     = cmd_op;
      p_val    = cmd_value;
      p_rep    = cmd_rep;
      p_load   = load;
      p_updown = updown;
      p_data   = data;
      @(posedge clk);
      last_accept = p_push;
      if (p_rst) begin
         m_q.delete();
         m_lvl = 0; m_run = 1'b0;
         m_load = 1'b1; m_data = 4'h0; m_updown = 1'b0; m_exp = 4'h0;
`ifdef CNT_DRV_WRAP_FLAG_EN
         m_wrap = 1'b0;
`endif
         c_cnt = 4'h0;
      end else begin
         if (m_load)        e_new = m_data;
         else if (m_updown) e_new = m_exp + 4'd1;
         else               e_new = m_exp - 4'd1;
`ifdef CNT_DRV_WRAP_FLAG_EN
         m_wrap = !m_load && ((m_updown && m_exp == 4'hF) || (!m_updown && m_exp == 4'h0));
`endif
         if (m_q.size() > 0) begin
            s = m_q.pop_front();
            if (s.first) m_lvl--;
            m_run = 1'b1;
         end else begin
            s = '{op: OP_HOLD, value: 4'h0, first: 1'b0};
            m_run = 1'b0;
         end
         case (s.op)
            OP_LOAD: begin m_load = 1'b1; m_data = s.value; end
            OP_UP:   begin m_load = 1'b0; m_updown = 1'b1; end
            OP_DOWN: begin m_load = 1'b0; m_updown = 1'b0; end
            default: begin m_load = 1'b1; m_data = e_new; end
         endcase
         m_exp = e_new;
         if (p_push) begin
            for (int i = 0; i <= int'(p_rep); i++) m_q.push_back('{op: p_op, value: p_val, first: (i == 0)});
            m_lvl++;
         end
         if (p_load)        c_cnt = p_data;
         else if (p_updown) c_cnt = c_cnt + 4'd1;
         else               c_cnt = c_cnt - 4'd1;
      end
      #1;
      check_val("load", {31'b0, load}, {31'b0, m_load});
      check_val("data", {28'b0, data}, {28'b0, m_data});
      check_val("updown", {31'b0, updown}, {31'b0, m_updown});
      check_val("exp_count", {28'b0, exp_count}, {28'b0, m_exp});
      check_val("counter_vs_exp", {28'b0, exp_count}, {28'b0, c_cnt});
      check_val("fifo_level", {29'b0, fifo_level}, 32'(m_lvl));
      check_val("busy", {31'b0, busy}, {31'b0, (m_run || m_lvl != 0)});
`ifdef CNT_DRV_WRAP_FLAG_EN
      check_val("wrap", {31'b0, wrap}, {31'b0, m_wrap});
`endif
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] v, input logic [REP_W-1:0] r);
      bit done = 1'b0;
      cmd_valid = 1'b1; cmd_op = op; cmd_value = v; cmd_rep = r;
      for (int i = 0; i < 64 && !done; i++) begin
         tick();
         done = last_accept;
      end
      cmd_valid = 1'b0;
      check_val("send_accepted", {31'b0, done}, 32'd1);
   endtask

   initial begin
      logic [WIDTH-1:0] e0;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);

      // reset in the middle of a running command with a part-filled FIFO
      send(OP_UP, 4'h0, 4'd15);
      send(OP_LOAD, 4'h3, 4'd0);
      send(OP_DOWN, 4'h0, 4'd1);
      idle(2);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      check_val("t1_load", {31'b0, load}, 32'd1);
      check_val("t1_data", {28'b0, data}, 32'd0);
      check_val("t1_exp", {28'b0, exp_count}, 32'd0);
      check_val("t1_level", {29'b0, fifo_level}, 32'd0);
      check_val("t1_busy", {31'b0, busy}, 32'd0);
      idle(2);

      send(OP_LOAD, 4'h7, 4'd0);
      send(OP_UP, 4'h0, 4'd2);
      idle(6);
      check_val("t2_final", {28'b0, exp_count}, 32'hA);

      send(OP_LOAD, 4'hF, 4'd0);
      send(OP_UP, 4'h0, 4'd0);
      idle(4);
      check_val("t3_up_wrap", {28'b0, exp_count}, 32'h0);
      send(OP_LOAD, 4'h0, 4'd0);
      send(OP_DOWN, 4'h0, 4'd0);
      idle(4);
      check_val("t3_down_wrap", {28'b0, exp_count}, 32'hF);

      // FIFO fills behind a long command; the next push must wait for a pop
      send(OP_UP, 4'h0, 4'd15);
      send(OP_LOAD, 4'h3, 4'd1);
      send(OP_DOWN, 4'h0, 4'd2);
      send(OP_HOLD, 4'h0, 4'd0);
      send(OP_UP, 4'h0, 4'd1);
      check_val("t4_level_full", {29'b0, fifo_level}, 32'd4);
      check_val("t4_ready_low", {31'b0, cmd_ready}, 32'd0);
      send(OP_LOAD, 4'h9, 4'd0);
      idle(24);

      // push coincides with the pop of the head at level 2
      send(OP_UP, 4'h0, 4'd3);
      send(OP_DOWN, 4'h0, 4'd1);
      send(OP_HOLD, 4'h0, 4'd3);
      idle(2);
      send(OP_LOAD, 4'h5, 4'd0);
      check_val("t5_level_same", {29'b0, fifo_level}, 32'd2);
      idle(20);

      e0 = m_exp;
      for (int i = 0; i < 10; i++) begin
         idle(1);
         check_val("t6_idle_load", {31'b0, load}, 32'd1);
         check_val("t6_idle_data", {28'b0, data}, {28'b0, e0});
         check_val("t6_idle_exp", {28'b0, exp_count}, {28'b0, e0});
      end

      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 149) == 0);
         cmd_valid = $urandom_range(0, 1) != 0;
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_value = 4'($urandom_range(0, 15));
         cmd_rep   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
         tick();
      end
      rst = 1'b0;
      idle(40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
